// File: rtl/rv32i_operand_fetch.sv
// rv32i_operand_fetch
//   Operand-fetch sequencer between the decoder and execute. A decoded
//   instruction is accepted in IDLE. Each required source register is read
//   from a 16-bit-wide register file as two half-word beats (low, then high),
//   reassembled into 32 bits, patched by in-flight writebacks, and presented
//   to execute.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
//   ready are both high. o_valid holds, with its data, until i_ready. ready
//   never depends on valid.
//
// Ports
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_valid / o_ready       decoder handshake (o_ready only in IDLE, low in reset)
//   i_instr                 instruction word, captured on accept
//   i_rs1_addr, i_rs2_addr  source register indices
//   i_rs1_use, i_rs2_use    operand-required flags
//   o_rf_rd_en/addr/hi      half-word read request (hi=0 -> [15:0], hi=1 -> [31:16])
//   i_rf_rd_data            read data, returned exactly one cycle after a request
//   i_wb_en/addr/data       writeback committing this cycle (forwarding source)
//   o_valid / i_ready       execute handshake
//   o_instr                 captured instruction
//   o_rs1_data, o_rs2_data  assembled operands
//   o_dbg_state             current FSM state (debug visibility)

module rv32i_operand_fetch (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_instr,
   input  logic [4:0]  i_rs1_addr,
   input  logic [4:0]  i_rs2_addr,
   input  logic        i_rs1_use,
   input  logic        i_rs2_use,
   output logic        o_rf_rd_en,
   output logic [4:0]  o_rf_rd_addr,
   output logic        o_rf_rd_hi,
   input  logic [15:0] i_rf_rd_data,
   input  logic        i_wb_en,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instr,
   output logic [31:0] o_rs1_data,
   output logic [31:0] o_rs2_data,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_R1L   = 3'd1,
      S_R1H   = 3'd2,
      S_R2L   = 3'd3,
      S_R2H   = 3'd4,
      S_CAPT  = 3'd5,
      S_VALID = 3'd6
   } state_t;

   state_t     state;
   logic [4:0] rs1_addr_q, rs2_addr_q;
   logic       rs1_fetch_q, rs2_fetch_q;   // operand is actually read (used and not x0)
   logic       fwd1_q, fwd2_q;             // sticky: writeback already supplied all 32 bits
   logic       cap_en_q;                   // read data arrives this cycle
   logic       cap_op2_q;                  // ... and belongs to operand 2
   logic       cap_hi_q;                   // ... and is the upper half

   logic acc_fetch1, acc_fetch2;
   logic wb_hit1, wb_hit2;
   logic cap1, cap2;

   assign acc_fetch1 = i_rs1_use && (i_rs1_addr != 5'd0);
   assign acc_fetch2 = i_rs2_use && (i_rs2_addr != 5'd0);

   // Forwarding window spans every non-IDLE state, including the handshake
   // cycle in VALID. The fetch flag already excludes x0.
   assign wb_hit1 = (state != S_IDLE) && rs1_fetch_q && i_wb_en && (i_wb_addr == rs1_addr_q);
   assign wb_hit2 = (state != S_IDLE) && rs2_fetch_q && i_wb_en && (i_wb_addr == rs2_addr_q);

   // Once forwarded, the BRAM copy is stale and must not overwrite it.
   assign cap1 = cap_en_q && !cap_op2_q && !fwd1_q;
   assign cap2 = cap_en_q &&  cap_op2_q && !fwd2_q;

   assign o_ready     = (state == S_IDLE) && !i_rst;
   assign o_dbg_state = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         o_valid      <= 1'b0;
         o_rf_rd_en   <= 1'b0;
         o_rf_rd_addr <= 5'd0;
         o_rf_rd_hi   <= 1'b0;
         o_instr      <= 32'd0;
         o_rs1_data   <= 32'd0;
         o_rs2_data   <= 32'd0;
         rs1_addr_q   <= 5'd0;
         rs2_addr_q   <= 5'd0;
         rs1_fetch_q  <= 1'b0;
         rs2_fetch_q  <= 1'b0;
         fwd1_q       <= 1'b0;
         fwd2_q       <= 1'b0;
         cap_en_q     <= 1'b0;
         cap_op2_q    <= 1'b0;
         cap_hi_q     <= 1'b0;
      end else begin
         // Remember what the outstanding request was so the returning beat
         // lands in the right half of the right operand.
         cap_en_q  <= o_rf_rd_en;
         cap_op2_q <= (state == S_R2L) || (state == S_R2H);
         cap_hi_q  <= o_rf_rd_hi;

         case (state)
            S_IDLE: begin
               o_valid <= 1'b0;
               if (i_valid) begin
                  o_instr     <= i_instr;
                  rs1_addr_q  <= i_rs1_addr;
                  rs2_addr_q  <= i_rs2_addr;
                  rs1_fetch_q <= acc_fetch1;
                  rs2_fetch_q <= acc_fetch2;
                  o_rs1_data  <= 32'd0;
                  o_rs2_data  <= 32'd0;
                  fwd1_q      <= 1'b0;
                  fwd2_q      <= 1'b0;
                  if (acc_fetch1) begin
                     state        <= S_R1L;
                     o_rf_rd_en   <= 1'b1;
                     o_rf_rd_addr <= i_rs1_addr;
                     o_rf_rd_hi   <= 1'b0;
                  end else if (acc_fetch2) begin
                     state        <= S_R2L;
                     o_rf_rd_en   <= 1'b1;
                     o_rf_rd_addr <= i_rs2_addr;
                     o_rf_rd_hi   <= 1'b0;
                  end else begin
                     state   <= S_VALID;
                     o_valid <= 1'b1;
                  end
               end
            end
            S_R1L: begin
               state        <= S_R1H;
               o_rf_rd_en   <= 1'b1;
               o_rf_rd_addr <= rs1_addr_q;
               o_rf_rd_hi   <= 1'b1;
            end
            S_R1H: begin
               if (rs2_fetch_q) begin
                  state        <= S_R2L;
                  o_rf_rd_en   <= 1'b1;
                  o_rf_rd_addr <= rs2_addr_q;
                  o_rf_rd_hi   <= 1'b0;
               end else begin
                  state        <= S_CAPT;
                  o_rf_rd_en   <= 1'b0;
                  o_rf_rd_addr <= 5'd0;
                  o_rf_rd_hi   <= 1'b0;
               end
            end
            S_R2L: begin
               state        <= S_R2H;
               o_rf_rd_en   <= 1'b1;
               o_rf_rd_addr <= rs2_addr_q;
               o_rf_rd_hi   <= 1'b1;
            end
            S_R2H: begin
               state        <= S_CAPT;
               o_rf_rd_en   <= 1'b0;
               o_rf_rd_addr <= 5'd0;
               o_rf_rd_hi   <= 1'b0;
            end
            S_CAPT: begin
               // Waits for the last beat to land before presenting.
               state   <= S_VALID;
               o_valid <= 1'b1;
            end
            S_VALID: begin
               if (i_ready) begin
                  state   <= S_IDLE;
                  o_valid <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               o_valid    <= 1'b0;
               o_rf_rd_en <= 1'b0;
            end
         endcase

         // Operand updates. Hits are impossible in IDLE, so these never
         // collide with the clear on accept.
         if (wb_hit1) begin
            o_rs1_data <= i_wb_data;
            fwd1_q     <= 1'b1;
         end else if (cap1) begin
            if (cap_hi_q) o_rs1_data[31:16] <= i_rf_rd_data;
            else          o_rs1_data[15:0]  <= i_rf_rd_data;
         end

         if (wb_hit2) begin
            o_rs2_data <= i_wb_data;
            fwd2_q     <= 1'b1;
         end else if (cap2) begin
            if (cap_hi_q) o_rs2_data[31:16] <= i_rf_rd_data;
            else          o_rs2_data[15:0]  <= i_rf_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_rv32i_operand_fetch.sv
module tb_rv32i_operand_fetch;

   // ---------------- clock / reset / signals ----------------
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_instr;
   logic [4:0]  i_rs1_addr, i_rs2_addr;
   logic        i_rs1_use, i_rs2_use;
   logic        o_rf_rd_en;
   logic [4:0]  o_rf_rd_addr;
   logic        o_rf_rd_hi;
   logic [15:0] i_rf_rd_data;
   logic        i_wb_en;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instr;
   logic [31:0] o_rs1_data, o_rs2_data;
   logic [2:0]  o_dbg_state;

   always #5 i_clk = ~i_clk;

   rv32i_operand_fetch dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_instr      (i_instr),
      .i_rs1_addr   (i_rs1_addr),
      .i_rs2_addr   (i_rs2_addr),
      .i_rs1_use    (i_rs1_use),
      .i_rs2_use    (i_rs2_use),
      .o_rf_rd_en   (o_rf_rd_en),
      .o_rf_rd_addr (o_rf_rd_addr),
      .o_rf_rd_hi   (o_rf_rd_hi),
      .i_rf_rd_data (i_rf_rd_data),
      .i_wb_en      (i_wb_en),
      .i_wb_addr    (i_wb_addr),
      .i_wb_data    (i_wb_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_instr      (o_instr),
      .o_rs1_data   (o_rs1_data),
      .o_rs2_data   (o_rs2_data),
      .o_dbg_state  (o_dbg_state)
   );

   // ---------------- register-file model (1-cycle read) ----------------
   logic [31:0] rf [32];

   always @(posedge i_clk) begin
      if (o_rf_rd_en)
         i_rf_rd_data <= o_rf_rd_hi ? rf[o_rf_rd_addr][31:16] : rf[o_rf_rd_addr][15:0];
      else
         i_rf_rd_data <= 16'($urandom);
   end

   // ---------------- scoreboard state ----------------
   int n_chk  = 0;
   int n_pass = 0;
   int cyc;
   logic [9:0] rd_q[$];          // observed requests {cycle[3:0], addr, hi}

   // writeback plan indexed by cycle relative to accept (0 = accept cycle)
   logic        wb_en_a   [32];
   logic [4:0]  wb_addr_a [32];
   logic [31:0] wb_data_a [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_rf_rd_en) rd_q.push_back({cyc[3:0], o_rf_rd_addr, o_rf_rd_hi});
   endtask

   task automatic clear_wb();
      for (int k = 0; k < 32; k++) begin
         wb_en_a[k]   = 1'b0;
         wb_addr_a[k] = 5'd0;
         wb_data_a[k] = 32'd0;
      end
   endtask

   task automatic rand_wb(input logic [4:0] a1, input logic [4:0] a2);
      for (int k = 0; k < 32; k++) begin
         wb_en_a[k]   = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       wb_addr_a[k] = a1;
            1:       wb_addr_a[k] = a2;
            2:       wb_addr_a[k] = 5'd0;
            default: wb_addr_a[k] = 5'($urandom);
         endcase
         wb_data_a[k] = $urandom;
      end
   endtask

   task automatic drive_wb(input int c);
      if (c >= 0 && c < 32) begin
         i_wb_en   = wb_en_a[c];
         i_wb_addr = wb_addr_a[c];
         i_wb_data = wb_data_a[c];
      end else begin
         i_wb_en = 1'b0;
      end
   endtask

   // Reference: a fetched operand ends up as its RF value, replaced by the
   // latest matching writeback seen in cycles 1..upto-1 after accept.
   function automatic logic [31:0] exp_op(input logic fetched, input logic [4:0] a, input int upto);
      logic [31:0] v;
      if (!fetched) return 32'd0;
      v = rf[a];
      for (int k = 1; k < upto && k < 32; k++)
         if (wb_en_a[k] && wb_addr_a[k] == a) v = wb_data_a[k];
      return v;
   endfunction

   // ---------------- driver + checks for one instruction ----------------
   task automatic run_txn(input string nm, input logic [31:0] instr,
                          input logic [4:0] a1, input logic [4:0] a2,
                          input logic u1, input logic u2, input int hold);
      logic       f1, f2;
      int         lat;
      logic [3:0] c4;
      logic [9:0] exp_q[$];
      f1  = u1 && (a1 != 5'd0);
      f2  = u2 && (a2 != 5'd0);
      lat = (f1 && f2) ? 6 : ((f1 || f2) ? 4 : 1);
      c4  = 4'd1;
      if (f1) begin
         exp_q.push_back({c4, a1, 1'b0}); c4++;
         exp_q.push_back({c4, a1, 1'b1}); c4++;
      end
      if (f2) begin
         exp_q.push_back({c4, a2, 1'b0}); c4++;
         exp_q.push_back({c4, a2, 1'b1}); c4++;
      end

      // accept cycle
      chk({nm, ":ready_idle"}, 32'(o_ready), 32'd1);
      i_valid = 1'b1; i_instr = instr;
      i_rs1_addr = a1; i_rs2_addr = a2; i_rs1_use = u1; i_rs2_use = u2;
      drive_wb(0);
      rd_q.delete();
      cyc = 0;
      step();
      i_valid = 1'b0;
      i_instr = $urandom; i_rs1_addr = 5'($urandom); i_rs2_addr = 5'($urandom);
      i_rs1_use = 1'($urandom); i_rs2_use = 1'($urandom);

      while (!o_valid && cyc < 20) begin
         drive_wb(cyc);
         step();
      end
      chk({nm, ":latency"}, 32'(cyc), 32'(lat));
      if (!o_valid) begin
         i_wb_en = 1'b0;
         return;
      end

      for (int h = 0; h <= hold; h++) begin
         chk({nm, ":valid"}, 32'(o_valid), 32'd1);
         chk({nm, ":ready_busy"}, 32'(o_ready), 32'd0);
         chk({nm, ":instr"}, o_instr, instr);
         chk({nm, ":rs1"}, o_rs1_data, exp_op(f1, a1, cyc));
         chk({nm, ":rs2"}, o_rs2_data, exp_op(f2, a2, cyc));
         i_ready = (h == hold);
         drive_wb(cyc);
         step();
      end
      i_ready = 1'b0;
      i_wb_en = 1'b0;
      chk({nm, ":ready_after"}, 32'(o_ready), 32'd1);
      chk({nm, ":valid_after"}, 32'(o_valid), 32'd0);
      chk({nm, ":rs1_after"}, o_rs1_data, exp_op(f1, a1, cyc));
      chk({nm, ":rs2_after"}, o_rs2_data, exp_op(f2, a2, cyc));

      chk({nm, ":rd_count"}, 32'(rd_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
         chk({nm, ":rd_seq"}, 32'(rd_q[i]), 32'(exp_q[i]));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_instr = 32'd0;
      i_rs1_addr = 5'd0; i_rs2_addr = 5'd0; i_rs1_use = 1'b0; i_rs2_use = 1'b0;
      i_wb_en = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0; i_ready = 1'b0;
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      rf[3] = 32'h1111_1111;
      rf[5] = 32'h1234_5678;
      rf[6] = 32'hCAFE_BABE;
      rf[7] = 32'hDEAD_BEEF;
      clear_wb();
      cyc = 0;

      step(); step(); step();
      chk("rst:ready_low", 32'(o_ready), 32'd0);
      i_rst = 1'b0;
      #1;
      chk("rst:ready", 32'(o_ready), 32'd1);
      chk("rst:valid", 32'(o_valid), 32'd0);
      chk("rst:rd_en", 32'(o_rf_rd_en), 32'd0);
      chk("rst:rd_addr", 32'(o_rf_rd_addr), 32'd0);
      chk("rst:rd_hi", 32'(o_rf_rd_hi), 32'd0);
      chk("rst:rs1", o_rs1_data, 32'd0);
      chk("rst:rs2", o_rs2_data, 32'd0);
      chk("rst:instr", o_instr, 32'd0);

      // both operands
      clear_wb();
      run_txn("both", 32'h0062_82B3, 5'd5, 5'd6, 1'b1, 1'b1, 0);
      // rs1 = x0, only rs2 read
      run_txn("rs2only", 32'h0070_0333, 5'd0, 5'd7, 1'b1, 1'b1, 0);
      // nothing used
      run_txn("none", 32'h0000_0013, 5'd5, 5'd6, 1'b0, 1'b0, 0);

      // forward into rs1 during R1H, then an x0 write that must be ignored
      clear_wb();
      wb_en_a[2] = 1'b1; wb_addr_a[2] = 5'd3; wb_data_a[2] = 32'hAAAA_5555;
      wb_en_a[3] = 1'b1; wb_addr_a[3] = 5'd0; wb_data_a[3] = 32'h0BAD_0BAD;
      run_txn("fwd_r1h", 32'h0001_8093, 5'd3, 5'd0, 1'b1, 1'b0, 0);

      // hold in VALID with a writeback to rs2 in the middle of the hold
      clear_wb();
      wb_en_a[7] = 1'b1; wb_addr_a[7] = 5'd6; wb_data_a[7] = 32'h5A5A_0F0F;
      run_txn("hold", 32'h0062_82B3, 5'd5, 5'd6, 1'b1, 1'b1, 3);

      // reset while in R2L
      clear_wb();
      i_valid = 1'b1; i_instr = 32'h00A4_8533;
      i_rs1_addr = 5'd9; i_rs2_addr = 5'd10; i_rs1_use = 1'b1; i_rs2_use = 1'b1;
      step();
      i_valid = 1'b0;
      step(); step();
      chk("midrst:in_r2l", {o_rf_rd_addr, o_rf_rd_hi}, {5'd10, 1'b0});
      i_rst = 1'b1;
      #1;
      chk("midrst:ready_low", 32'(o_ready), 32'd0);
      step();
      chk("midrst:rd_en", 32'(o_rf_rd_en), 32'd0);
      chk("midrst:rd_addr", 32'(o_rf_rd_addr), 32'd0);
      chk("midrst:valid", 32'(o_valid), 32'd0);
      chk("midrst:rs1", o_rs1_data, 32'd0);
      chk("midrst:rs2", o_rs2_data, 32'd0);
      chk("midrst:instr", o_instr, 32'd0);
      i_rst = 1'b0;
      #1;
      chk("midrst:ready", 32'(o_ready), 32'd1);
      step();
      chk("midrst:rs1_late", o_rs1_data, 32'd0);
      run_txn("after_rst", 32'h0072_8233, 5'd5, 5'd7, 1'b1, 1'b1, 1);

      // randomized instructions with random writeback traffic
      for (int t = 0; t < 40; t++) begin
         logic [4:0] a1, a2;
         a1 = 5'($urandom_range(0, 7));
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
         rand_wb(a1, a2);
         run_txn("rand", $urandom, a1, a2, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
